store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Data-memory store buffer directly downstream of the write stage.
- Accepts memory-destination writes (address_enable/address/data) and answers with data_valid, which releases the write stage's hold.
- Queues accepted stores in a small FIFO and drains them, oldest first, to the data bus using a waitrequest-style handshake.
- Provides store-to-load forwarding of still-buffered data and an empty flag for fences.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of two, at least 2.
- WIDTH, 32, address and data width (the regval_t width).

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  synchronous, active-high reset.
- address_enable  in  1  write stage requests a store this cycle.
- address  in  WIDTH  store address from the write stage.
- data  in  WIDTH  store data from the write stage.
- data_valid  out  1  store accepted this cycle (combinational).
- bus_address  out  WIDTH  address of the head entry.
- bus_writedata  out  WIDTH  data of the head entry.
- bus_write  out  1  head entry is presented to the bus.
- bus_waitrequest  in  1  bus not ready; the presented write is not taken.
- lookup_address  in  WIDTH  load address to check against buffered stores.
- lookup_hit  out  1  at least one buffered entry matches lookup_address.
- lookup_data  out  WIDTH  data of the youngest matching entry; 0 when there is no hit.
- empty  out  1  no buffered stores.
- count  out  $clog2(DEPTH)+1  number of buffered stores.

Behaviour:
- Storage: circular FIFO of DEPTH {address, data} entries.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a registered occupancy counter.
- Reset (synchronous, at a clock edge with reset high):
  - Head, tail and count go to 0, so all buffered stores are discarded.
  - While reset is high: data_valid=0, bus_write=0, lookup_hit=0, lookup_data=0, empty=1.
  - bus_address and bus_writedata are don't-care while bus_write=0.
- Accept:
  - data_valid = address_enable && count!=DEPTH && !reset, with zero latency, in the same cycle as the request.
  - On an accepting edge, {address, data} is written at the tail, the tail advances, and the entry is buffered from the next cycle.
  - When count==DEPTH, data_valid=0 even if a pop happens in the same cycle; the request is retried next cycle.
  - The write stage holds its request stable while data_valid=0.
- Drain:
  - bus_write = count!=0 && !reset.
  - bus_address and bus_writedata come straight from the head entry registers.
  - Pop when bus_write && !bus_waitrequest: the head advances at that edge.
  - While bus_waitrequest=1, the head entry and bus outputs stay stable.
  - Back-to-back pops are allowed, one per cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Push into an empty buffer: the entry appears on the bus in the next cycle, never in the same cycle.
- Forwarding:
  - Compare lookup_address against every valid entry (those between head and tail, counted by count).
  - Youngest means closest to the tail.
  - The entry popping this cycle still counts. The entry being accepted this cycle does not count until the next cycle.
  - Forwarding is purely combinational.
- empty = count==0.
- Ordering: stores reach the bus in strict acceptance order; same-address stores are never merged.

Test Plan:
- Single store, bus ready: address_enable=1, address=0x100, data=0xDEADBEEF at cycle 0.
  - Cycle 0: data_valid=1.
  - Cycle 1: bus_write=1, bus_address=0x100, bus_writedata=0xDEADBEEF.
  - Cycle 2: empty=1.
- Fill with bus stalled: bus_waitrequest=1, push 4 stores (0x10..0x13, data 1..4).
  - count=4.
  - A 5th request sees data_valid=0 for as long as waitrequest stays high.
  - Release waitrequest: bus shows 0x10,0x11,0x12,0x13 on consecutive cycles.
  - The 5th store is accepted in the cycle after the first pop.
- Wrap-around: push and drain 10 stores at one push per cycle with the bus ready.
  - All 10 appear in order.
  - count never exceeds 2.
  - Pointers wrap with no loss or duplication.
- Forwarding, bus stalled:
  - Buffer (0x20,0xA), (0x24,0xB), (0x20,0xC).
  - lookup_address=0x20 -> lookup_hit=1, lookup_data=0xC.
  - lookup_address=0x28 -> lookup_hit=0, lookup_data=0.
- Reset mid-operation: 3 entries buffered, bus stalled, reset high for 1 cycle.
  - During reset: bus_write=0, data_valid=0.
  - After reset: count=0, empty=1, and none of the discarded stores ever appear on the bus.
- Push while popping at count=2: count stays 2 and the order is preserved.

Source files
------------

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Data-memory store buffer sitting right after the write stage. Accepted
//   stores are queued in a circular FIFO and drained oldest-first to the data
//   bus with a waitrequest handshake. Still-buffered stores can be forwarded
//   to a load via a combinational address lookup (youngest match wins).
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   address_enable/address/data   store request from the write stage
//   data_valid              store accepted this cycle (combinational)
//   bus_address/bus_writedata     head entry presented to the bus
//   bus_write               head entry valid on the bus
//   bus_waitrequest         bus not ready; presented write not taken
//   lookup_address          load address to search for
//   lookup_hit/lookup_data  forwarding result (data is 0 on a miss)
//   empty                   no buffered stores (used by fences)
//   count                   number of buffered stores
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     address_enable,
  input  logic [WIDTH-1:0]         address,
  input  logic [WIDTH-1:0]         data,
  output logic                     data_valid,
  output logic [WIDTH-1:0]         bus_address,
  output logic [WIDTH-1:0]         bus_writedata,
  output logic                     bus_write,
  input  logic                     bus_waitrequest,
  input  logic [WIDTH-1:0]         lookup_address,
  output logic                     lookup_hit,
  output logic [WIDTH-1:0]         lookup_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] addr_d [DEPTH];
  logic [WIDTH-1:0] wdata_q [DEPTH];
  logic [WIDTH-1:0] wdata_d [DEPTH];

  logic push;
  logic pop;

  // A full buffer refuses even if a pop happens this cycle; keeps the accept
  // path independent of the bus handshake.
  assign data_valid    = address_enable && (count_q != CW'(DEPTH)) && !reset;
  assign bus_write     = (count_q != '0) && !reset;
  assign bus_address   = addr_q[head_q];
  assign bus_writedata = wdata_q[head_q];
  assign empty         = (count_q == '0) || reset;
  assign count         = count_q;

  assign push = data_valid;
  assign pop  = bus_write && !bus_waitrequest;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (reset) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        addr_d[tail_q]  = address;
        wdata_d[tail_q] = data;
        tail_d          = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clock) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // NOTE: the entry storage is deliberately not reset; validity is tracked
  // by head/count alone, so stale contents are never observed.
  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Walk entries from oldest to youngest; a later match overwrites an earlier
  // one so the youngest matching store wins. The entry being accepted this
  // cycle is not yet counted, the one popping this cycle still is.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == lookup_address)) begin
        lookup_hit  = 1'b1;
        lookup_data = wdata_q[head_q + PW'(i)];
      end
    end
    if (reset) begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Self-checking bench for store_buffer. A queue holds the buffered stores
//   in acceptance order; every cycle the expected outputs are derived from
//   that queue and compared. Directed scenarios add literal expectations,
//   followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
  } ent_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] dat;
  logic             dv;
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_d;
  logic             bw;
  logic             wr;
  logic [WIDTH-1:0] la;
  logic             hit;
  logic [WIDTH-1:0] ld;
  logic             emp;
  logic [2:0]       cnt;

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  logic last_dv;

  always #5 clock = ~clock;

  store_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .address_enable (en),
    .address        (addr),
    .data           (dat),
    .data_valid     (dv),
    .bus_address    (bus_a),
    .bus_writedata  (bus_d),
    .bus_write      (bw),
    .bus_waitrequest(wr),
    .lookup_address (la),
    .lookup_hit     (hit),
    .lookup_data    (ld),
    .empty          (emp),
    .count          (cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock cycle: compare against the queue model, take the edge, then
  // update the model with what must have happened at that edge.
  task automatic cycle();
    logic             e_dv, e_bw, e_hit, pop;
    logic [WIDTH-1:0] e_ld;
    #1;
    e_dv  = en && (q.size() != DEPTH) && !reset;
    e_bw  = (q.size() != 0) && !reset;
    e_hit = 1'b0;
    e_ld  = '0;
    if (!reset) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == la) begin
          e_hit = 1'b1;
          e_ld  = q[i].d;
          break;
        end
      end
    end
    check("m_data_valid", 32'(dv), 32'(e_dv));
    check("m_bus_write", 32'(bw), 32'(e_bw));
    if (e_bw) begin
      check("m_bus_address", bus_a, q[0].a);
      check("m_bus_writedata", bus_d, q[0].d);
    end
    check("m_lookup_hit", 32'(hit), 32'(e_hit));
    check("m_lookup_data", ld, e_ld);
    check("m_empty", 32'(emp), 32'((q.size() == 0) || reset));
    check("m_count", 32'(cnt), 32'(q.size()));
    last_dv = e_dv;
    pop     = e_bw && !wr;
    @(posedge clock);
    if (reset) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (e_dv) q.push_back('{a: addr, d: dat});
    end
    @(negedge clock);
  endtask

  task automatic push_stalled(input logic [31:0] a, input logic [31:0] d);
    en   = 1'b1;
    addr = a;
    dat  = d;
    cycle();
    en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; addr = '0; dat = '0; wr = 1'b0; la = '0;
    last_dv = 1'b0;
    @(negedge clock);

    // Reset state
    settle();
    check("rst_empty", 32'(emp), 32'd1);
    check("rst_bus_write", 32'(bw), 32'd0);
    check("rst_data_valid", 32'(dv), 32'd0);
    cycle();
    reset = 1'b0; en = 1'b0;
    cycle();

    // Single store, bus ready
    en = 1'b1; addr = 32'h100; dat = 32'hDEADBEEF;
    settle();
    check("single_dv", 32'(dv), 32'd1);
    check("single_no_bus_same_cycle", 32'(bw), 32'd0);
    cycle();
    en = 1'b0;
    settle();
    check("single_bw", 32'(bw), 32'd1);
    check("single_addr", bus_a, 32'h100);
    check("single_data", bus_d, 32'hDEADBEEF);
    cycle();
    settle();
    check("single_empty", 32'(emp), 32'd1);

    // Fill with bus stalled, then release
    wr = 1'b1;
    for (int i = 0; i < 4; i++) push_stalled(32'h10 + 32'(i), 32'(i + 1));
    settle();
    check("fill_count", 32'(cnt), 32'd4);
    en = 1'b1; addr = 32'h14; dat = 32'd5;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("fill_full_dv", 32'(dv), 32'd0);
      cycle();
    end
    wr = 1'b0;
    settle();
    check("drain0_addr", bus_a, 32'h10);
    check("drain0_dv", 32'(dv), 32'd0);
    cycle();
    settle();
    check("drain1_addr", bus_a, 32'h11);
    check("drain1_dv", 32'(dv), 32'd1);
    cycle();
    en = 1'b0;
    settle();
    check("drain2_addr", bus_a, 32'h12);
    check("drain2_count", 32'(cnt), 32'd3);
    cycle();
    settle();
    check("drain3_addr", bus_a, 32'h13);
    cycle();
    settle();
    check("drain4_addr", bus_a, 32'h14);
    check("drain4_data", bus_d, 32'd5);
    cycle();
    settle();
    check("drain_empty", 32'(emp), 32'd1);

    // Wrap-around: one push per cycle with bus ready
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; addr = 32'h200 + 32'(4 * i); dat = 32'(i);
      settle();
      check("wrap_count_le2", 32'(cnt <= 3'd2), 32'd1);
      cycle();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    settle();
    check("wrap_empty", 32'(emp), 32'd1);

    // Forwarding with bus stalled
    wr = 1'b1;
    push_stalled(32'h20, 32'hA);
    push_stalled(32'h24, 32'hB);
    push_stalled(32'h20, 32'hC);
    la = 32'h20;
    settle();
    check("fwd_hit", 32'(hit), 32'd1);
    check("fwd_data", ld, 32'hC);
    la = 32'h28;
    settle();
    check("fwd_miss_hit", 32'(hit), 32'd0);
    check("fwd_miss_data", ld, 32'd0);
    cycle();

    // Reset mid-operation with 3 entries buffered
    reset = 1'b1; en = 1'b1; addr = 32'h99; dat = 32'h99;
    settle();
    check("midrst_bw", 32'(bw), 32'd0);
    check("midrst_dv", 32'(dv), 32'd0);
    cycle();
    reset = 1'b0; en = 1'b0; wr = 1'b0;
    settle();
    check("midrst_count", 32'(cnt), 32'd0);
    check("midrst_empty", 32'(emp), 32'd1);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("midrst_no_stale_bw", 32'(bw), 32'd0);
      cycle();
    end

    // Push while popping at count=2
    wr = 1'b1;
    push_stalled(32'h30, 32'h1);
    push_stalled(32'h34, 32'h2);
    wr = 1'b0; en = 1'b1; addr = 32'h38; dat = 32'h3;
    settle();
    check("pp_count_before", 32'(cnt), 32'd2);
    cycle();
    en = 1'b0;
    settle();
    check("pp_count_after", 32'(cnt), 32'd2);
    check("pp_head", bus_a, 32'h34);
    cycle();
    settle();
    check("pp_next", bus_a, 32'h38);
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic; a refused request is held stable until accepted
    last_dv = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!en || last_dv) begin
        en   = ($urandom_range(0, 99) < 60);
        addr = 32'($urandom_range(0, 7)) << 2;
        dat  = $urandom;
      end
      wr    = ($urandom_range(0, 99) < 40);
      la    = 32'($urandom_range(0, 7)) << 2;
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
